// File: rtl/counter_sched_if.sv
// -----------------------------------------------------------------------------
// counter_sched_if
// Bundles the signals between the round-robin counter scheduler, its
// requesters and the shared free-running counter.
//
//   req        requester -> sched  per-requester request level
//   limit      requester -> sched  per-requester terminal count, WIDTH bits each
//   count      counter   -> sched  current value of the shared counter
//   cnt_clear  sched     -> counter synchronous clear of the shared counter
//   gnt        sched     -> requester one-hot grant (or all zero)
//   done       sched     -> requester one-cycle completion pulse
//   busy       sched     -> any      high while a job is running or clearing
//
// Modports:
//   slave  : the scheduler's view
//   master : the environment's view (requesters plus the counter)
// -----------------------------------------------------------------------------
interface counter_sched_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] limit;
   logic [WIDTH-1:0]      count;
   logic                  cnt_clear;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;

   modport slave (
      input  req,
      input  limit,
      input  count,
      output cnt_clear,
      output gnt,
      output done,
      output busy
   );

   modport master (
      output req,
      output limit,
      output count,
      input  cnt_clear,
      input  gnt,
      input  done,
      input  busy
   );
endinterface

// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
// Round-robin scheduler sharing one free-running counter among NREQ
// requesters. A granted requester gets the counter for limit+1 clocks; the
// scheduler watches count reach the latched limit, pulses done for one cycle,
// then spends one cycle holding the counter in clear before re-arbitrating.
//
// Ports:
//   clock  rising-edge clock
//   clear  synchronous active-high reset
//   bus    counter_sched_if.slave : req, limit, count in;
//                                   cnt_clear, gnt, done, busy out
//
// cnt_clear, gnt and done are registered; busy decodes the state register.
// -----------------------------------------------------------------------------
module counter_sched #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 8
) (
   input  logic            clock,
   input  logic            clear,
   counter_sched_if.slave  bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CLR  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;      // round-robin search start
   logic [PTR_W-1:0]  own_q, own_d;      // index of the granted requester
   logic [WIDTH-1:0]  lim_q, lim_d;      // limit frozen at the grant edge
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              cnt_clear_q, cnt_clear_d;

   // Per-requester view of the packed limit bus
   logic [WIDTH-1:0]  lim_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lim
         assign lim_arr[gi] = bus.limit[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Round-robin pick: scan offsets from the far end downwards so the
   // candidate closest to ptr is the last one written and therefore wins.
   logic [PTR_W-1:0]  sel_idx;
   logic              sel_vld;
   logic [PTR_W-1:0]  sel_nxt;

   always_comb begin
      int cand;
      cand    = 0;
      sel_idx = '0;
      sel_vld = 1'b0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         cand = int'(ptr_q) + off;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (bus.req[PTR_W'(cand)]) begin
            sel_idx = PTR_W'(cand);
            sel_vld = 1'b1;
         end
      end
   end

   // Pointer advances to the requester after the one just granted
   assign sel_nxt = (sel_idx == PTR_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      own_d       = own_q;
      lim_d       = lim_q;
      gnt_d       = gnt_q;
      done_d      = done_q;
      cnt_clear_d = cnt_clear_q;

      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            done_d      = '0;
            cnt_clear_d = 1'b1;
            if (sel_vld) begin
               own_d          = sel_idx;
               lim_d          = lim_arr[sel_idx];
               gnt_d[sel_idx] = 1'b1;
               cnt_clear_d    = 1'b0;
               ptr_d          = sel_nxt;
               state_d        = RUN;
            end
         end

         RUN: begin
            // A dropped request ends the grant quietly, even if the
            // terminal count was reached in the same cycle.
            if (!bus.req[own_q]) begin
               gnt_d       = '0;
               cnt_clear_d = 1'b1;
               state_d     = CLR;
            end else if (bus.count == lim_q) begin
               done_d        = '0;
               done_d[own_q] = 1'b1;
               gnt_d         = '0;
               cnt_clear_d   = 1'b1;
               state_d       = CLR;
            end
         end

         CLR: begin
            gnt_d       = '0;
            done_d      = '0;
            cnt_clear_d = 1'b1;
            state_d     = IDLE;
         end

         default: begin
            gnt_d       = '0;
            done_d      = '0;
            cnt_clear_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         own_q       <= '0;
         lim_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         cnt_clear_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         own_q       <= own_d;
         lim_q       <= lim_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         cnt_clear_q <= cnt_clear_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.cnt_clear = cnt_clear_q;
   assign bus.busy      = (state_q == RUN) || (state_q == CLR);

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one free-running `counter` datapath (ports `clock`, `clear`, `count`; synchronous clear to 0, otherwise +1 every clock) among `NREQ` requesters. Each requester asks for a timed interval of `limit+1` clocks. The scheduler grants one requester at a time and holds the counter in clear while it is idle. It watches `count` reach the granted requester's latched limit, then returns a one-cycle `done` pulse. It sits between the requesting blocks and the shared counter, and is the only driver of the counter's `clear` input.

## Interface
- `NREQ`, default 2: number of requesters, ≥2.
- `WIDTH`, default 8: counter width; must match the counter's `count` width.

- `clock`  in  1: single clock, rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester request level; held high until `done` or abort.
- `limit`  in  NREQ*WIDTH: per-requester terminal count; requester i occupies bits [i*WIDTH +: WIDTH].
- `count`  in  WIDTH: current value from the shared counter.
- `cnt_clear`  out  1: drives the counter's `clear`; registered.
- `gnt`  out  NREQ: one-hot grant, or all zero; registered.
- `done`  out  NREQ: one-cycle completion pulse to the granted requester; registered.
- `busy`  out  1: high while in RUN or CLR.

## Operation
- States: IDLE, RUN, CLR.
- Round-robin pointer `ptr`: search order is ptr, ptr+1, … mod NREQ.
- **IDLE**
  - `cnt_clear`=1, `gnt`=0.
  - If any `req` bit is high, select the first set bit in search order (index i).
  - At that edge: latch `limit[i]` into `lim_q`, set `gnt[i]`=1, `cnt_clear`=0, `ptr`←(i+1) mod NREQ, go to RUN.
- **RUN**
  - The counter is released; the first RUN cycle sees `count`=0.
  - Normal completion: when `count`==`lim_q` and `req[i]`=1, at the next edge set `done[i]`=1, `gnt`=0, `cnt_clear`=1, go to CLR.
  - Abort: if `req[i]` drops while in RUN, at the next edge set `gnt`=0, `cnt_clear`=1, go to CLR, with no `done` pulse. Abort takes priority over completion in the same cycle.
- **CLR**
  - One cycle; `cnt_clear`=1, so the counter returns to 0.
  - `done` is cleared at the end of this cycle; go to IDLE.
- `lim_q` is frozen for the whole grant; changes on `limit` after the grant edge are ignored.
- A requester that keeps `req` high after `done` is eligible again, but only in round-robin order.
- `limit`=0 is legal and gives a single RUN cycle. `limit`=2^WIDTH−1 is legal; the counter reaches it before wrapping.
- Only `count`==`lim_q` terminates a grant. The scheduler never uses a greater-than compare.

## Timing
- Reset values (`clear`=1): state=IDLE, `gnt`=0, `done`=0, `cnt_clear`=1, `busy`=0, `ptr`=0, `lim_q`=0.
- `clear` during RUN or CLR: return to the reset values on that edge, with no `done` pulse.
- Grant latency: `req` sampled high in IDLE at edge k, so `gnt` is high from cycle k+1.
- RUN lasts `lim_q`+1 cycles, with `count` going 0…`lim_q`.
- `done` is high during the CLR cycle, which is cycle k+`lim_q`+2. `gnt` is low in that same cycle.
- Per-job occupancy is `lim_q`+3 cycles. The next grant has the earliest rising edge at the end of the IDLE cycle that follows CLR.
- `busy` is combinational from state (RUN or CLR). All other outputs are registered.
- Simultaneous requests in IDLE: exactly one grant, chosen per `ptr`. Requests not granted remain pending; they are not lost.

## Test plan
- **Reset:** hold `clear`=1 for 3 cycles → `cnt_clear`=1, `gnt`=0, `done`=0, `busy`=0.
- **Single job:** `req`=01, `limit[0]`=5 → `gnt`=01 for 6 cycles while `count` goes 0..5. Then `done`=01 for exactly 1 cycle; `cnt_clear`=1 from the `done` cycle onward; `count` returns to 0.
- **Round-robin:** `req`=11 held high, `limit`={3,2} → grants alternate 01, 10, 01…, with `done` 5 and 6 cycles apart respectively.
- **Abort:** `req`=10, `limit[1]`=20, drop `req[1]` when `count`=7 → `gnt` goes 0 at the next edge, no `done`, state passes through CLR to IDLE.
- **Edge limits:**
  - `limit`=0 → RUN for 1 cycle and `done` 2 cycles after the grant.
  - `limit`=255 → `count` reaches 255 and `done` fires without the counter wrapping.
  - Changing `limit` mid-RUN has no effect.
- **Reset mid-RUN:** assert `clear` while `count`=4 → all outputs return to reset values at the next edge, with no `done`; after release, `ptr`=0 so requester 0 wins a tie.
